// File: rtl/flash_access_arbiter.sv
// Round-robin arbiter giving two requesters read access to two flash chips; ack arrives WAIT_CYCLES+2 edges after grant when flash_rdy is high.
// Requesters hold req until ack; optional WAIT abort under FLASH_ACCESS_TIMEOUT_EN.
module flash_access_arbiter #(
  parameter int N           = 16,
  parameter int WAIT_CYCLES = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic         clk,
  input  logic         nRESET,
  input  logic         req0,
  input  logic         req1,
  input  logic [N-1:0] addr0,
  input  logic [N-1:0] addr1,
  input  logic [7:0]   flash_data,
  input  logic         flash_rdy,
  output logic [7:0]   flash_sel_0,
  output logic [7:0]   flash_sel_1,
  output logic [1:0]   chip_select,
  output logic [12:0]  flash_addr,
  output logic         ack0,
  output logic         ack1,
  output logic         err,
  output logic [7:0]   rdata,
  output logic         busy
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(WAIT_CYCLES - 1);
  localparam logic [7:0] CNT_SAT  = 8'((TIMEOUT > WAIT_CYCLES) ? TIMEOUT : WAIT_CYCLES);

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_gnt;
  logic         r_last;
  logic [N-1:0] r_addr;
  logic [7:0]   r_cnt;
  logic [7:0]   r_cap_dat;
  logic         r_cap_err;
  logic [7:0]   r_sel0;
  logic [7:0]   r_sel1;
  logic [1:0]   r_cs;
  logic [12:0]  r_faddr;
  logic         r_ack0;
  logic         r_ack1;
  logic         r_err;
  logic [7:0]   r_rdata;
  logic         r_busy;

  logic [N-1:0] w_addr_hi;
  logic [1:0]   w_chip;
  logic         w_pick;
  logic         w_rdy_done;
  logic         w_abort;

  // r_addr only changes in IDLE, so the decode stays stable for the whole access.
  assign w_addr_hi = r_addr >> 13;

  always_comb begin
    w_chip = 2'b11;
    if (w_addr_hi == '0) begin
      w_chip = 2'b00;
    end else if (w_addr_hi == N'(1)) begin
      w_chip = 2'b01;
    end
  end

  assign w_pick     = (req0 && req1) ? ~r_last : req1;
  assign w_rdy_done = (r_cnt >= CNT_LAST) && flash_rdy;

`ifdef FLASH_ACCESS_TIMEOUT_EN
  localparam logic [7:0] CNT_ABORT = 8'(TIMEOUT - 1);
  assign w_abort = (r_cnt >= CNT_ABORT) && !flash_rdy;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req0 || req1) w_state_nxt = S_SETUP;
      S_SETUP: w_state_nxt = (w_chip == 2'b11) ? S_DONE : S_WAIT;
      S_WAIT:  if (w_rdy_done || w_abort) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      r_gnt     <= 1'b0;
      r_last    <= 1'b1;
      r_addr    <= '0;
      r_cnt     <= 8'd0;
      r_cap_dat <= 8'h00;
      r_cap_err <= 1'b0;
      r_faddr   <= 13'd0;
      r_err     <= 1'b0;
      r_rdata   <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req0 || req1) begin
            r_gnt  <= w_pick;
            r_addr <= w_pick ? addr1 : addr0;
          end
        end
        S_SETUP: begin
          r_cnt <= 8'd0;
          if (w_chip != 2'b11) begin
            r_faddr <= 13'(r_addr);
          end else begin
            r_cap_dat <= 8'h00;
            r_cap_err <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_cnt < CNT_SAT) r_cnt <= r_cnt + 8'd1;
          if (w_rdy_done) begin
            r_cap_dat <= flash_data;
            r_cap_err <= 1'b0;
          end else if (w_abort) begin
            r_cap_dat <= 8'h00;
            r_cap_err <= 1'b1;
          end
        end
        S_DONE: begin
          // rdata/err only move together with ack so they hold between completions.
          r_rdata <= r_cap_dat;
          r_err   <= r_cap_err;
          r_last  <= r_gnt;
        end
        default: ;
      endcase
    end
  end

  // Enables track the next state so they are active exactly in WAIT cycles.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      r_sel0 <= 8'hFF;
      r_sel1 <= 8'hFF;
      r_cs   <= 2'b11;
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_sel0 <= (w_state_nxt == S_WAIT && w_chip == 2'b00) ? 8'hFE : 8'hFF;
      r_sel1 <= (w_state_nxt == S_WAIT && w_chip == 2'b01) ? 8'hFD : 8'hFF;
      r_cs   <= (w_state_nxt == S_WAIT) ? w_chip : 2'b11;
      r_ack0 <= (r_state == S_DONE) && !r_gnt;
      r_ack1 <= (r_state == S_DONE) && r_gnt;
      r_busy <= (w_state_nxt != S_IDLE);
    end
  end

  assign flash_sel_0 = r_sel0;
  assign flash_sel_1 = r_sel1;
  assign chip_select = r_cs;
  assign flash_addr  = r_faddr;
  assign ack0        = r_ack0;
  assign ack1        = r_ack1;
  assign err         = r_err;
  assign rdata       = r_rdata;
  assign busy        = r_busy;

endmodule
